// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   state_e         : fetch FSM state encoding (IDLE=0, FETCH=1, HOLD=2)
//   WordW           : instruction / address width
//   DefaultResetPc  : default PC after Clr
//   align_word()    : clears address bits [1:0] to form a word address
package instruction_fetch_pkg;

  localparam int unsigned WordW = 32;
  localparam logic [WordW-1:0] DefaultResetPc = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2
  } state_e;

  function automatic logic [WordW-1:0] align_word(input logic [WordW-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter register for the fetch stage.
//   Clk      : clock, rising edge
//   Clr      : asynchronous active-high clear, loads ResetPc
//   load_i   : redirect; loads word-aligned target_i (wins over inc_i)
//   target_i : redirect address, bits [1:0] ignored
//   inc_i    : advance PC by PcStep (wraps mod 2^32)
//   pc_o     : current PC
module instruction_fetch_pc_reg
  import instruction_fetch_pkg::*;
#(
  parameter logic [WordW-1:0] ResetPc = DefaultResetPc,
  parameter int unsigned      PcStep  = 4
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             load_i,
  input  logic [WordW-1:0] target_i,
  input  logic             inc_i,
  output logic [WordW-1:0] pc_o
);

  logic [WordW-1:0] pc_q;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      pc_q <= ResetPc;
    end else if (load_i) begin
      pc_q <= align_word(target_i);
    end else if (inc_i) begin
      pc_q <= pc_q + WordW'(PcStep);
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage feeding the ARM datapath. Owns the PC, reads instruction memory over a
// req/ack handshake and presents one instruction at a time, honouring stall and branch.
//   Clk, Clr        : clock (rising edge), asynchronous active-high reset
//   imem_req/addr   : fetch request and word address (addr = PC)
//   imem_ack/rdata  : memory read data valid / instruction word
//   stall           : datapath cannot accept the presented instruction this edge
//   branch_taken    : one-cycle redirect pulse to branch_target (bits [1:0] forced 0)
//   instr/_valid/_pc: presented instruction, live flag and its fetch address
//   fetch_count     : number of instructions accepted by the datapath (wraps)
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [WordW-1:0] RESET_PC = DefaultResetPc,
  parameter int unsigned      PC_STEP  = 4,
  parameter int unsigned      CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Clr,
  output logic             imem_req,
  output logic [WordW-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WordW-1:0] imem_rdata,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WordW-1:0] branch_target,
  output logic [WordW-1:0] instr,
  output logic             instr_valid,
  output logic [WordW-1:0] instr_pc,
  output logic [CNT_W-1:0] fetch_count
);

  state_e           state_q;
  logic [WordW-1:0] instr_q;
  logic             instr_valid_q;
  logic [WordW-1:0] instr_pc_q;
  logic [CNT_W-1:0] fetch_count_q;
  logic [WordW-1:0] pc;
  logic             load_word;
  logic             accept;

  // In HOLD the request is withheld while stalled so the held word is never overwritten.
  assign imem_req  = (state_q == StFetch) || ((state_q == StHold) && !stall);
  assign imem_addr = pc;

  // A branch on the same edge discards any returning word.
  assign load_word = imem_req && imem_ack && !branch_taken;
  assign accept    = instr_valid_q && !stall;

  instruction_fetch_pc_reg #(
    .ResetPc (RESET_PC),
    .PcStep  (PC_STEP)
  ) u_pc_reg (
    .Clk      (Clk),
    .Clr      (Clr),
    .load_i   (branch_taken),
    .target_i (branch_target),
    .inc_i    (load_word),
    .pc_o     (pc)
  );

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q       <= StIdle;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      instr_pc_q    <= '0;
      fetch_count_q <= '0;
    end else begin
      // Counts independently of the redirect: an instruction taken on a branch edge is real.
      if (accept) begin
        fetch_count_q <= fetch_count_q + CNT_W'(1);
      end

      if (branch_taken) begin
        state_q       <= StFetch;
        instr_valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StFetch;
          end
          StFetch: begin
            if (load_word) begin
              instr_q       <= imem_rdata;
              instr_pc_q    <= pc;
              instr_valid_q <= 1'b1;
              state_q       <= StHold;
            end
          end
          StHold: begin
            if (!stall) begin
              if (load_word) begin
                instr_q    <= imem_rdata;
                instr_pc_q <= pc;
              end else begin
                instr_valid_q <= 1'b0;
                state_q       <= StFetch;
              end
            end
          end
          default: begin
            state_q       <= StIdle;
            instr_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch. Acked words are pushed to a scoreboard with the
// address the bench expects them to come from; they are popped when the datapath accepts.
// A second instance with RESET_PC=FFFF_FFFC and a 4-bit counter covers PC and count wrap.
module tb_instruction_fetch;

  logic        Clk;
  logic        Clr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [15:0] fetch_count;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_stall;
  logic        w_br;
  logic [31:0] w_tgt;
  logic [31:0] w_instr;
  logic        w_valid;
  logic [31:0] w_instr_pc;
  logic [3:0]  w_count;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_pc;
  logic [15:0] m_cnt;

  instruction_fetch u_dut (
    .Clk           (Clk),
    .Clr           (Clr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_pc      (instr_pc),
    .fetch_count   (fetch_count)
  );

  instruction_fetch #(
    .RESET_PC (32'hFFFF_FFFC),
    .CNT_W    (4)
  ) u_wrap (
    .Clk           (Clk),
    .Clr           (Clr),
    .imem_req      (w_req),
    .imem_addr     (w_addr),
    .imem_ack      (w_ack),
    .imem_rdata    (w_rdata),
    .stall         (w_stall),
    .branch_taken  (w_br),
    .branch_target (w_tgt),
    .instr         (w_instr),
    .instr_valid   (w_valid),
    .instr_pc      (w_instr_pc),
    .fetch_count   (w_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic front(output exp_t x);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'(sb.size()), 32'd1);
      x.word = 32'hx;
      x.pc   = 32'hx;
    end else begin
      x = sb[0];
    end
  endtask

  // One clock cycle of the main DUT with expected req / valid given by the step.
  task automatic cyc(input logic ack, input logic [31:0] rd, input logic st, input logic br,
                     input logic [31:0] tgt, input logic e_req, input logic e_valid);
    exp_t x;
    imem_ack      = ack;
    imem_rdata    = rd;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    #1;
    chk("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", 32'(instr_valid), 32'(e_valid));
    if (e_valid) begin
      front(x);
      chk("instr", instr, x.word);
      chk("instr_pc", instr_pc, x.pc);
      if (!st) begin
        if (sb.size() != 0) void'(sb.pop_front());
        m_cnt = m_cnt + 16'd1;
      end else if (br) begin
        if (sb.size() != 0) void'(sb.pop_front());  // squashed by redirect
      end
    end
    if (br) begin
      m_pc = {tgt[31:2], 2'b00};
    end else if (ack && e_req) begin
      e.word = rd;
      e.pc   = m_pc;
      sb.push_back(e);
      m_pc = m_pc + 32'd4;
    end
    tick();
    chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
  endtask

  initial begin
    Clr = 1'b1;
    imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    w_ack = 1'b0; w_rdata = '0; w_stall = 1'b0; w_br = 1'b0; w_tgt = '0;
    m_pc = 32'h0; m_cnt = 16'h0;
    tick();
    tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_count", 32'(fetch_count), 32'd0);
    Clr = 1'b0;

    // Reset: one dead IDLE cycle, then FETCH; Clr mid-FETCH drops req at once
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, 32'h0);
    Clr = 1'b1;
    #1;
    chk("clr_req_drop", 32'(imem_req), 32'd0);
    tick();
    Clr = 1'b0;
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Zero-wait stream
    cyc(1'b1, 32'h03B0_1001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 32'h03B0_10AA, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b1, 32'h03B0_A0BA, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b1, 32'h03B0_A0FF, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("stream_count", 32'(fetch_count), 32'd4);

    // Wait states: address held, no valid until the ack edge
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 32'h1111_2222, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Stall for 5 cycles in HOLD, then release
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 32'h3333_4444, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("stall_count", 32'(fetch_count), 32'd6);

    // Branch during ack: word discarded, fetch resumes at 0x100
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b0);
    cyc(1'b1, 32'h5555_0100, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 32'h5555_0104, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    // Branch while stalled: held word squashed, not counted
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b1);
    cyc(1'b1, 32'h6666_0200, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    // Branch while accepted: instruction still counted
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0307, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("branch_count", 32'(fetch_count), 32'd8);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // PC wrap and counter rollover on the second instance
    for (int i = 0; i < 18; i++) begin
      w_ack   = 1'b1;
      w_rdata = 32'hA000_0000 + 32'(i);
      #1;
      chk("wrap_req", 32'(w_req), 32'd1);
      chk("wrap_addr", w_addr, 32'hFFFF_FFFC + 32'(4 * i));
      chk("wrap_valid", 32'(w_valid), (i >= 1) ? 32'd1 : 32'd0);
      if (i >= 1) begin
        chk("wrap_instr", w_instr, 32'hA000_0000 + 32'(i - 1));
        chk("wrap_instr_pc", w_instr_pc, 32'hFFFF_FFFC + 32'(4 * (i - 1)));
      end
      tick();
      chk("wrap_count", 32'(w_count), 32'(i % 16));
    end
    w_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
